// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI boot loader: FSM states, default sync marker, word width.
package spi_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_FINISH,
        S_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;
    localparam int         WORD_W         = 32;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian byte-to-word assembler: shifts bytes in and emits a registered one-cycle
// word-ready pulse together with the finished word on the cycle after the 4th byte.
module loader_word_asm
    import spi_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_rdy
);

    logic [WORD_W-9:0] shreg;
    logic [1:0]        cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            cnt      <= '0;
            word     <= '0;
            word_rdy <= 1'b0;
        end else begin
            word_rdy <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (byte_vld) begin
                cnt <= cnt + 2'd1;
                // Word output only changes on completion so write data stays stable between writes.
                if (cnt == 2'd3) begin
                    word     <= {shreg, byte_in};
                    word_rdy <= 1'b1;
                end else begin
                    shreg <= {shreg[WORD_W-17:0], byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/spi_prog_loader.sv
// Boot-frame loader: parses SYNC/LEN/data bytes from the SPI receiver into instruction memory
// and holds the core in reset while loading. Define LOADER_CSUM_EN to require a sum trailer byte.
module spi_prog_loader
    import spi_loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT,
    parameter bit         BOOT_RUN  = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_stb,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [16:0]       CAPACITY = 17'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    state_t      state;
    logic        stb_d;
    logic        pend_vld;
    logic [7:0]  pend_byte;
    logic        byte_vld;
    logic [7:0]  byte_val;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [15:0] wcnt;
    logic        sync_hit;
    logic        asm_vld;

    // A byte landing in the FINISH cycle is parked and replayed in IDLE one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stb_d     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_byte <= '0;
        end else begin
            stb_d    <= i_byte_stb;
            pend_vld <= stb_d && (state == S_FINISH);
            if (stb_d)
                pend_byte <= i_byte;
        end
    end

    assign byte_vld = (stb_d && (state != S_FINISH)) || pend_vld;
    assign byte_val = pend_vld ? pend_byte : i_byte;
    assign len      = {len_hi, byte_val};
    assign sync_hit = byte_vld && (byte_val == SYNC_BYTE) && (state == S_IDLE || state == S_ERR);
    assign asm_vld  = byte_vld && (state == S_DATA);

    loader_word_asm u_word_asm (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clr      (sync_hit),
        .byte_vld (asm_vld),
        .byte_in  (byte_val),
        .word     (o_mem_wdata),
        .word_rdy (o_mem_we)
    );

`ifdef LOADER_CSUM_EN
    logic [7:0] csum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            csum <= '0;
        else if (sync_hit)
            csum <= '0;
        else if (asm_vld)
            csum <= csum + byte_val;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            len_hi      <= '0;
            wcnt        <= '0;
            o_mem_addr  <= BASE;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
            o_cpu_rst_n <= BOOT_RUN;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (sync_hit) begin
                        state       <= S_LEN_HI;
                        o_busy      <= 1'b1;
                        o_cpu_rst_n <= 1'b0;
                        o_err       <= 1'b0;
                        o_mem_addr  <= BASE;
                    end
                end
                S_LEN_HI: begin
                    if (byte_vld) begin
                        len_hi <= byte_val;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (byte_vld) begin
                        wcnt <= len;
                        if (len == 16'd0) begin
`ifdef LOADER_CSUM_EN
                            state <= S_CSUM;
`else
                            state       <= S_FINISH;
                            o_busy      <= 1'b0;
                            o_cpu_rst_n <= 1'b1;
`endif
                        end else if ({1'b0, len} > CAPACITY) begin
                            state  <= S_ERR;
                            o_err  <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // Bookkeeping runs in the write cycle, in parallel with any byte arriving then.
                    if (o_mem_we) begin
                        o_mem_addr <= o_mem_addr + ADDR_W'(1);
                        wcnt       <= wcnt - 16'd1;
                        if (wcnt == 16'd1) begin
`ifdef LOADER_CSUM_EN
                            state <= S_CSUM;
`else
                            state       <= S_FINISH;
                            o_busy      <= 1'b0;
                            o_cpu_rst_n <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_CSUM_EN
                S_CSUM: begin
                    if (byte_vld) begin
                        if (byte_val == csum) begin
                            state       <= S_FINISH;
                            o_busy      <= 1'b0;
                            o_cpu_rst_n <= 1'b1;
                        end else begin
                            state  <= S_ERR;
                            o_err  <= 1'b1;
                            o_busy <= 1'b0;
                        end
                    end
                end
`endif
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Bench for spi_prog_loader: directed and random boot frames checked against a frame-level model.
// Honours LOADER_CSUM_EN the same way the design does.
module tb_spi_prog_loader;

    localparam int ADDR_W = 10;
    localparam int CAP    = 1 << ADDR_W;
    localparam bit BOOT_RUN = 1'b0;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [7:0]        i_byte = 8'h00;
    logic              i_byte_stb = 1'b0;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              o_cpu_rst_n;
    logic              o_busy;
    logic              o_err;

    spi_prog_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (0),
        .SYNC_BYTE (8'hA5),
        .BOOT_RUN  (BOOT_RUN)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_byte      (i_byte),
        .i_byte_stb  (i_byte_stb),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_cpu_rst_n (o_cpu_rst_n),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int nvec = 0;
    int nerr = 0;
    string step = "reset";

    int wr_seen = 0;
    always @(negedge i_clk) if (o_mem_we === 1'b1) wr_seen++;

    // Frame-level reference: phase 0 hunting for sync (also covers the error state),
    // 1/2 length bytes, 3 data bytes, 4 checksum trailer.
    int          phase = 0;
    int          nlen = 0;
    int          nbytes = 0;
    int          waddr = 0;
    int          wr_exp = 0;
    logic [31:0] acc = '0;
    logic [7:0]  sum = '0;
    bit          m_busy = 1'b0, m_run = BOOT_RUN, m_err = 1'b0;
    bit          e_we;
    logic [31:0] e_data;
    int          e_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s/%s: observed %h expected %h", step, tag, obs, exp);
        end
    endtask

    task automatic m_finish();
        m_busy = 1'b0;
        m_run  = 1'b1;
        phase  = 0;
    endtask

    task automatic m_after_data();
`ifdef LOADER_CSUM_EN
        phase = 4;
`else
        m_finish();
`endif
    endtask

    task automatic m_byte(input logic [7:0] b);
        e_we = 1'b0;
        case (phase)
            0: if (b == 8'hA5) begin
                phase = 1; m_busy = 1'b1; m_run = 1'b0; m_err = 1'b0; waddr = 0;
            end
            1: begin nlen = int'(b) << 8; phase = 2; end
            2: begin
                nlen += int'(b); nbytes = 0; sum = 8'h00;
                if (nlen == 0) m_after_data();
                else if (nlen > CAP) begin m_err = 1'b1; m_busy = 1'b0; phase = 0; end
                else phase = 3;
            end
            3: begin
                acc = {acc[23:0], b}; sum = sum + b; nbytes++;
                if (nbytes % 4 == 0) begin
                    e_we = 1'b1; e_data = acc; e_addr = waddr;
                    waddr = (waddr + 1) % CAP; wr_exp++;
                    if (nbytes == 4 * nlen) m_after_data();
                end
            end
            4: if (b == sum) m_finish(); else begin m_err = 1'b1; m_busy = 1'b0; phase = 0; end
            default: phase = 0;
        endcase
    endtask

    task automatic chk_status();
        chk("busy", o_busy, m_busy);
        chk("err", o_err, m_err);
        chk("cpu_rst_n", o_cpu_rst_n, m_run);
        chk("writes", wr_seen, wr_exp);
    endtask

    // Called 1 time unit after a rising edge; strobe this cycle, byte valid the next.
    task automatic send(input logic [7:0] b, input int tail);
        i_byte_stb = 1'b1; i_byte = 8'($urandom);
        @(posedge i_clk); #1;
        i_byte_stb = 1'b0; i_byte = b;
        m_byte(b);
        @(posedge i_clk); #1;
        i_byte = 8'($urandom);
        chk("mem_we", o_mem_we, e_we);
        if (e_we) begin
            chk("mem_addr", o_mem_addr, e_addr);
            chk("mem_wdata", o_mem_wdata, e_data);
            chk("held_in_write", o_cpu_rst_n, 1'b0);
        end
        if (tail > 0) begin
            @(posedge i_clk); #1;
            chk_status();
            repeat (tail - 1) begin @(posedge i_clk); #1; end
        end
    endtask

    task automatic send_bytes(input logic [8*16-1:0] bytes, input int n, input int tail);
        for (int i = 0; i < n; i++) send(bytes[8*(n-1-i) +: 8], tail);
    endtask

    task automatic end_frame();
`ifdef LOADER_CSUM_EN
        send(sum, 15);
`endif
    endtask

    task automatic chk_reset_vals();
        chk("rst_we", o_mem_we, 1'b0);
        chk("rst_addr", o_mem_addr, '0);
        chk("rst_wdata", o_mem_wdata, '0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_cpu", o_cpu_rst_n, BOOT_RUN);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int n;
        repeat (3) @(posedge i_clk);
        #1;
        chk_reset_vals();
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        step = "two_words";
        send_bytes(88'hA5_00_02_DE_AD_BE_EF_01_23_45_67, 11, 15);
        end_frame();

        step = "garbage_then_frame";
        send_bytes(24'h00_FF_5A, 3, 15);
        send_bytes(56'hA5_00_01_11_22_33_44, 7, 15);
        end_frame();

        step = "empty_frame";
        send_bytes(24'hA5_00_00, 3, 15);
        end_frame();

        step = "too_long";
        send_bytes(24'hA5_04_01, 3, 15);
        chk("err_set", o_err, 1'b1);
        step = "recover";
        send_bytes(56'hA5_00_01_CA_FE_F0_0D, 7, 15);
        end_frame();

        step = "max_len_then_reset";
        send_bytes(40'hA5_04_00_12_34, 5, 15);
        i_rst_n = 1'b0;
        #3;
        chk_reset_vals();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        phase = 0; m_busy = 1'b0; m_run = BOOT_RUN; m_err = 1'b0;
        @(posedge i_clk); #1;
        send_bytes(56'hA5_00_01_55_66_77_88, 7, 15);
        end_frame();

        step = "sync_in_finish";
        send_bytes(48'hA5_00_01_CA_FE_BA, 6, 15);
`ifdef LOADER_CSUM_EN
        send(8'hBE, 15);
        send(sum, 0);
`else
        send(8'hBE, 0);
`endif
        send_bytes(56'hA5_00_01_A5_A5_00_A5, 7, 15);
        end_frame();

`ifdef LOADER_CSUM_EN
        step = "csum_bad";
        send_bytes(64'hA5_00_01_01_02_03_04_0B, 8, 15);
        chk("csum_err", o_err, 1'b1);
        step = "csum_good";
        send_bytes(64'hA5_00_01_01_02_03_04_0A, 8, 15);
`endif

        for (int k = 0; k < 6; k++) begin
            step = $sformatf("random_%0d", k);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send(b, 15);
            end
            n = int'($urandom_range(1, 4));
            send(8'hA5, 15);
            send(8'(n >> 8), 15);
            send(8'(n), 15);
            for (int i = 0; i < 4 * n; i++) begin
                b = (i == 1) ? 8'hA5 : 8'($urandom);
                send(b, 15);
            end
            end_frame();
        end

        step = "end";
        repeat (4) @(posedge i_clk);
        #1;
        chk_status();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
